// File: rtl/ps2_note_decoder_if.sv
// Scan-code input and tone/status output bundle between the PS/2 receiver,
// the note decoder and the audio output stage.
interface ps2_note_decoder_if #(
  parameter int unsigned SAMPLE_W = 32
);
  logic [7:0]                 received_data;
  logic                       received_data_en;
  logic                       key_held;
  logic [2:0]                 note_index;
  logic [16:0]                half_period;
  logic [7:0]                 last_code;
  logic                       tone_phase;
  logic signed [SAMPLE_W-1:0] sample;

  modport master (
    output received_data, received_data_en,
    input  key_held, note_index, half_period, last_code, tone_phase, sample
  );

  modport slave (
    input  received_data, received_data_en,
    output key_held, note_index, half_period, last_code, tone_phase, sample
  );
endinterface

// File: rtl/ps2_note_decoder.sv
// PS/2 scan-code parser with a held-key model that drives a square-wave
// sample for notes C4..C5 mapped onto eight home-row keys.
module ps2_note_decoder #(
  parameter logic signed [31:0] AMPLITUDE = 32'sd10000000,
  parameter int unsigned        SAMPLE_W  = 32
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  ps2_note_decoder_if.slave bus
);

  localparam int unsigned HP_W = 17;
  localparam logic [7:0]  C_E0 = 8'hE0;
  localparam logic [7:0]  C_F0 = 8'hF0;
  localparam logic signed [SAMPLE_W-1:0] L_POS = SAMPLE_W'(AMPLITUDE);
  localparam logic signed [SAMPLE_W-1:0] L_NEG = SAMPLE_W'(-AMPLITUDE);

  typedef enum logic [1:0] {P_IDLE, P_E0, P_F0, P_E0F0} state_t;

  state_t                     r_state, w_state_next;
  logic                       r_key_held;
  logic [2:0]                 r_note_index;
  logic [HP_W-1:0]            r_half_period;
  logic [7:0]                 r_last_code;
  logic [7:0]                 r_held_code;
  logic [HP_W-1:0]            r_cnt;
  logic                       r_tone_phase;
  logic signed [SAMPLE_W-1:0] r_sample;

  logic                       w_make, w_break, w_mapped, w_restart, w_wrap;
  logic [2:0]                 w_map_note;
  logic [HP_W-1:0]            w_map_hp;

  // Key map: make code to note index and half period in CLOCK_50 cycles
  always_comb begin
    w_mapped   = 1'b1;
    w_map_note = 3'd0;
    w_map_hp   = '0;
    case (bus.received_data)
      8'h1C: begin w_map_note = 3'd0; w_map_hp = 17'd95556; end
      8'h1B: begin w_map_note = 3'd1; w_map_hp = 17'd85131; end
      8'h23: begin w_map_note = 3'd2; w_map_hp = 17'd75843; end
      8'h2B: begin w_map_note = 3'd3; w_map_hp = 17'd71586; end
      8'h34: begin w_map_note = 3'd4; w_map_hp = 17'd63776; end
      8'h33: begin w_map_note = 3'd5; w_map_hp = 17'd56818; end
      8'h3B: begin w_map_note = 3'd6; w_map_hp = 17'd50619; end
      8'h42: begin w_map_note = 3'd7; w_map_hp = 17'd47778; end
      default: w_mapped = 1'b0;
    endcase
  end

  // Parser next state; extended (E0-prefixed) sequences are swallowed
  always_comb begin
    w_state_next = r_state;
    w_make       = 1'b0;
    w_break      = 1'b0;
    if (bus.received_data_en) begin
      case (r_state)
        P_IDLE: begin
          if (bus.received_data == C_E0)      w_state_next = P_E0;
          else if (bus.received_data == C_F0) w_state_next = P_F0;
          else                                w_make       = 1'b1;
        end
        P_E0:    w_state_next = (bus.received_data == C_F0) ? P_E0F0 : P_IDLE;
        P_F0: begin
          if (bus.received_data != C_F0) begin
            w_break      = 1'b1;
            w_state_next = P_IDLE;
          end
        end
        P_E0F0:  w_state_next = P_IDLE;
        default: w_state_next = P_IDLE;
      endcase
    end
  end

  // A typematic repeat of the sounding note must not restart the tone
  assign w_restart = w_make && w_mapped && (!r_key_held || (w_map_note != r_note_index));
  assign w_wrap    = (r_cnt == (r_half_period - HP_W'(1)));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state       <= P_IDLE;
      r_key_held    <= 1'b0;
      r_note_index  <= '0;
      r_half_period <= '0;
      r_last_code   <= '0;
      r_held_code   <= '0;
      r_cnt         <= '0;
      r_tone_phase  <= 1'b0;
      r_sample      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_make) r_last_code <= bus.received_data;

      if (w_make && w_mapped) begin
        r_key_held    <= 1'b1;
        r_note_index  <= w_map_note;
        r_half_period <= w_map_hp;
        r_held_code   <= bus.received_data;
      end else if (w_break && (bus.received_data == r_held_code)) begin
        r_key_held <= 1'b0;
      end

      if (w_restart) begin
        r_cnt        <= '0;
        r_tone_phase <= 1'b1;
      end else if (r_key_held) begin
        if (w_wrap) begin
          r_cnt        <= '0;
          r_tone_phase <= ~r_tone_phase;
        end else begin
          r_cnt <= r_cnt + HP_W'(1);
        end
      end else begin
        r_cnt        <= '0;
        r_tone_phase <= 1'b0;
      end

      r_sample <= r_key_held ? (r_tone_phase ? L_POS : L_NEG) : '0;
    end
  end

  assign bus.key_held    = r_key_held;
  assign bus.note_index  = r_note_index;
  assign bus.half_period = r_half_period;
  assign bus.last_code   = r_last_code;
  assign bus.tone_phase  = r_tone_phase;
  assign bus.sample      = r_sample;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Self-checking bench for ps2_note_decoder: directed scenarios plus random
// scan-code streams against a key-held/tone reference model.
module tb_ps2_note_decoder;

  localparam int unsigned       SAMPLE_W = 32;
  localparam logic signed [31:0] AMP     = 32'sd10000000;

  logic clk   = 1'b0;
  logic rstn  = 1'b1;

  ps2_note_decoder_if #(.SAMPLE_W(SAMPLE_W)) bus ();

  ps2_note_decoder #(.AMPLITUDE(AMP), .SAMPLE_W(SAMPLE_W)) dut (
    .CLOCK_50 (clk),
    .resetn   (rstn),
    .bus      (bus)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int unsigned code_tab [8] = '{'h1C, 'h1B, 'h23, 'h2B, 'h34, 'h33, 'h3B, 'h42};
  int unsigned hp_tab   [8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};
  longint            now     = 0;
  longint            m_start = 0;
  bit                m_held  = 0, m_phase = 0, m_pe0 = 0, m_pf0 = 0;
  logic [7:0]        m_last  = '0, m_code = '0;
  int                m_note  = 0, m_hp = 0;
  logic signed [31:0] m_sample = '0;

  function automatic int find_key(logic [7:0] b);
    for (int i = 0; i < 8; i++) if (code_tab[i] == 32'(b)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_held = 0; m_phase = 0; m_pe0 = 0; m_pf0 = 0;
    m_last = '0; m_code = '0; m_note = 0; m_hp = 0; m_sample = '0;
  endtask

  task automatic model_make(logic [7:0] b);
    int i;
    m_last = b;
    i = find_key(b);
    if (i >= 0) begin
      if (!m_held || m_note != i) begin
        m_start = now;
        m_phase = 1;
      end
      m_held = 1; m_note = i; m_hp = int'(hp_tab[i]); m_code = b;
    end
  endtask

  task automatic model_byte(logic [7:0] b);
    if (m_pe0 && m_pf0) begin
      m_pe0 = 0; m_pf0 = 0;
    end else if (m_pe0) begin
      if (b == 8'hF0) m_pf0 = 1; else m_pe0 = 0;
    end else if (m_pf0) begin
      if (b != 8'hF0) begin
        if (b == m_code) m_held = 0;
        m_pf0 = 0;
      end
    end else if (b == 8'hE0) m_pe0 = 1;
    else if (b == 8'hF0) m_pf0 = 1;
    else model_make(b);
  endtask

  // One clock: drive inputs, advance, then update the model to match the new cycle
  task automatic step(input bit en, input logic [7:0] b);
    bit hd, ph;
    hd = m_held; ph = m_phase;
    bus.received_data    = en ? b : 8'($urandom);
    bus.received_data_en = en;
    @(posedge clk);
    #1;
    bus.received_data_en = 1'b0;
    now++;
    if (!rstn) begin
      model_reset();
      return;
    end
    m_sample = hd ? (ph ? AMP : -AMP) : '0;
    m_phase  = hd ? (((now - m_start) / m_hp) % 2 == 0) : 1'b0;
    if (en) model_byte(b);
  endtask

  task automatic test_reset();
    #5 rstn = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step(0, 8'h00);
    vectors += 6;
    if (bus.key_held !== 1'b0)    begin errors++; $display("FAIL reset_key_held got=%0d exp=0", bus.key_held); end
    if (bus.note_index !== 3'd0)  begin errors++; $display("FAIL reset_note_index got=%0d exp=0", bus.note_index); end
    if (bus.half_period !== 17'd0) begin errors++; $display("FAIL reset_half_period got=%0d exp=0", bus.half_period); end
    if (bus.last_code !== 8'h00)  begin errors++; $display("FAIL reset_last_code got=%h exp=00", bus.last_code); end
    if (bus.tone_phase !== 1'b0)  begin errors++; $display("FAIL reset_tone_phase got=%0d exp=0", bus.tone_phase); end
    if (bus.sample !== 32'sd0)    begin errors++; $display("FAIL reset_sample got=%0d exp=0", bus.sample); end
    rstn = 1'b1;
    step(0, 8'h00);
  endtask

  task automatic test_c4_tone();
    step(1, 8'h1C);
    vectors += 5;
    if (bus.key_held !== 1'b1)        begin errors++; $display("FAIL c4_key_held got=%0d exp=1", bus.key_held); end
    if (bus.note_index !== 3'd0)      begin errors++; $display("FAIL c4_note got=%0d exp=0", bus.note_index); end
    if (bus.half_period !== 17'd95556) begin errors++; $display("FAIL c4_half_period got=%0d exp=95556", bus.half_period); end
    if (bus.tone_phase !== 1'b1)      begin errors++; $display("FAIL c4_phase got=%0d exp=1", bus.tone_phase); end
    if (bus.last_code !== 8'h1C)      begin errors++; $display("FAIL c4_last_code got=%h exp=1c", bus.last_code); end
    step(0, 8'h00);
    vectors++;
    if (bus.sample !== AMP) begin errors++; $display("FAIL c4_sample got=%0d exp=%0d", bus.sample, AMP); end
    for (int i = 0; i < 50; i++) step(0, 8'h00);
    vectors += 2;
    if (bus.tone_phase !== 1'b1) begin errors++; $display("FAIL c4_phase_hold got=%0d exp=1", bus.tone_phase); end
    if (bus.sample !== AMP)      begin errors++; $display("FAIL c4_sample_hold got=%0d exp=%0d", bus.sample, AMP); end
    step(1, 8'hF0);
    step(1, 8'h1C);
    vectors++;
    if (bus.key_held !== 1'b0) begin errors++; $display("FAIL c4_release got=%0d exp=0", bus.key_held); end
    step(0, 8'h00);
    vectors += 2;
    if (bus.sample !== 32'sd0)   begin errors++; $display("FAIL c4_release_sample got=%0d exp=0", bus.sample); end
    if (bus.tone_phase !== 1'b0) begin errors++; $display("FAIL c4_release_phase got=%0d exp=0", bus.tone_phase); end
  endtask

  task automatic test_supersede();
    step(1, 8'h1C);
    for (int i = 0; i < 20; i++) step(0, 8'h00);
    step(1, 8'h42);
    vectors += 4;
    if (bus.note_index !== 3'd7)       begin errors++; $display("FAIL sup_note got=%0d exp=7", bus.note_index); end
    if (bus.half_period !== 17'd47778) begin errors++; $display("FAIL sup_half_period got=%0d exp=47778", bus.half_period); end
    if (bus.tone_phase !== 1'b1)       begin errors++; $display("FAIL sup_phase got=%0d exp=1", bus.tone_phase); end
    if (bus.tone_phase !== m_phase)    begin errors++; $display("FAIL sup_phase_model got=%0d exp=%0d", bus.tone_phase, m_phase); end
    step(1, 8'hF0);
    step(1, 8'h1C);
    vectors++;
    if (bus.key_held !== 1'b1) begin errors++; $display("FAIL sup_stale_break got=%0d exp=1", bus.key_held); end
    step(0, 8'h00);
    step(1, 8'hF0);
    step(1, 8'h42);
    vectors++;
    if (bus.key_held !== 1'b0) begin errors++; $display("FAIL sup_release got=%0d exp=0", bus.key_held); end
  endtask

  task automatic test_extended();
    step(1, 8'hE0); step(1, 8'h1C);
    vectors++;
    if (bus.key_held !== 1'b0) begin errors++; $display("FAIL ext_make_held got=%0d exp=0", bus.key_held); end
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h1C);
    vectors += 2;
    if (bus.key_held !== 1'b0)   begin errors++; $display("FAIL ext_break_held got=%0d exp=0", bus.key_held); end
    if (bus.last_code !== 8'h42) begin errors++; $display("FAIL ext_last_code got=%h exp=42", bus.last_code); end
    step(1, 8'h1B);
    vectors += 3;
    if (bus.key_held !== 1'b1)         begin errors++; $display("FAIL ext_idle_held got=%0d exp=1", bus.key_held); end
    if (bus.note_index !== 3'd1)       begin errors++; $display("FAIL ext_idle_note got=%0d exp=1", bus.note_index); end
    if (bus.half_period !== 17'd85131) begin errors++; $display("FAIL ext_idle_hp got=%0d exp=85131", bus.half_period); end
    step(1, 8'hF0); step(1, 8'h1B); step(0, 8'h00);
  endtask

  // Held key with periodic typematic repeats; the half period must not stretch
  task automatic test_typematic();
    step(1, 8'h42);
    for (int i = 1; i <= 47800; i++) begin
      if (i % 1000 == 0) step(1, (i == 20000) ? 8'h15 : 8'h42);
      else               step(0, 8'h00);
      vectors += 3;
      if (bus.tone_phase !== m_phase) begin errors++; $display("FAIL typ_phase cyc=%0d got=%0d exp=%0d", i, bus.tone_phase, m_phase); end
      if (bus.sample !== m_sample)    begin errors++; $display("FAIL typ_sample cyc=%0d got=%0d exp=%0d", i, bus.sample, m_sample); end
      if (bus.note_index !== 3'd7)    begin errors++; $display("FAIL typ_note cyc=%0d got=%0d exp=7", i, bus.note_index); end
      if (i == 47777) begin
        vectors++;
        if (bus.tone_phase !== 1'b1) begin errors++; $display("FAIL typ_before_edge got=%0d exp=1", bus.tone_phase); end
      end
      if (i == 47778) begin
        vectors++;
        if (bus.tone_phase !== 1'b0) begin errors++; $display("FAIL typ_at_edge got=%0d exp=0", bus.tone_phase); end
      end
      if (i == 20000) begin
        vectors += 2;
        if (bus.last_code !== 8'h15) begin errors++; $display("FAIL typ_unmapped_last got=%h exp=15", bus.last_code); end
        if (bus.key_held !== 1'b1)   begin errors++; $display("FAIL typ_unmapped_held got=%0d exp=1", bus.key_held); end
      end
    end
    step(1, 8'hF0); step(1, 8'h42); step(0, 8'h00);
  endtask

  task automatic test_mid_reset();
    step(1, 8'h1C);
    for (int i = 0; i < 100; i++) step(0, 8'h00);
    #2 rstn = 1'b0;
    #1;
    vectors += 6;
    if (bus.key_held !== 1'b0)     begin errors++; $display("FAIL mrst_key_held got=%0d exp=0", bus.key_held); end
    if (bus.note_index !== 3'd0)   begin errors++; $display("FAIL mrst_note got=%0d exp=0", bus.note_index); end
    if (bus.half_period !== 17'd0) begin errors++; $display("FAIL mrst_hp got=%0d exp=0", bus.half_period); end
    if (bus.last_code !== 8'h00)   begin errors++; $display("FAIL mrst_last got=%h exp=00", bus.last_code); end
    if (bus.tone_phase !== 1'b0)   begin errors++; $display("FAIL mrst_phase got=%0d exp=0", bus.tone_phase); end
    if (bus.sample !== 32'sd0)     begin errors++; $display("FAIL mrst_sample got=%0d exp=0", bus.sample); end
    model_reset();
    for (int i = 0; i < 3; i++) step(0, 8'h00);
    rstn = 1'b1;
    step(1, 8'hF0); step(1, 8'h1C);
    vectors++;
    if (bus.key_held !== 1'b0) begin errors++; $display("FAIL mrst_lone_break got=%0d exp=0", bus.key_held); end
    step(0, 8'h00);
    vectors++;
    if (bus.sample !== 32'sd0) begin errors++; $display("FAIL mrst_after_sample got=%0d exp=0", bus.sample); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int sel, gap;
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 3)      b = 8'(code_tab[$urandom_range(0, 7)]);
      else if (sel <= 5) b = 8'hF0;
      else if (sel == 6) b = 8'hE0;
      else               b = 8'($urandom);
      step(1, b);
      vectors += 5;
      if (bus.key_held !== m_held)         begin errors++; $display("FAIL rnd_held n=%0d byte=%h got=%0d exp=%0d", n, b, bus.key_held, m_held); end
      if (bus.note_index !== 3'(m_note))   begin errors++; $display("FAIL rnd_note n=%0d got=%0d exp=%0d", n, bus.note_index, m_note); end
      if (bus.half_period !== 17'(m_hp))   begin errors++; $display("FAIL rnd_hp n=%0d got=%0d exp=%0d", n, bus.half_period, m_hp); end
      if (bus.last_code !== m_last)        begin errors++; $display("FAIL rnd_last n=%0d got=%h exp=%h", n, bus.last_code, m_last); end
      if (bus.tone_phase !== m_phase)      begin errors++; $display("FAIL rnd_phase n=%0d got=%0d exp=%0d", n, bus.tone_phase, m_phase); end
      gap = int'($urandom_range(0, 15));
      for (int g = 0; g < gap; g++) step(0, 8'h00);
      vectors += 2;
      if (bus.tone_phase !== m_phase) begin errors++; $display("FAIL rnd_gap_phase n=%0d got=%0d exp=%0d", n, bus.tone_phase, m_phase); end
      if (bus.sample !== m_sample)    begin errors++; $display("FAIL rnd_gap_sample n=%0d got=%0d exp=%0d", n, bus.sample, m_sample); end
    end
  endtask

  initial begin
    bus.received_data    = 8'h00;
    bus.received_data_en = 1'b0;
    test_reset();
    test_c4_tone();
    test_supersede();
    test_extended();
    test_typematic();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ps2_note_decoder.md
Name: ps2_note_decoder

Overview:
- Sits between the PS/2 keyboard receiver and the audio codec output stage.
- Parses the raw scan-code byte stream into make and break events, mapping eight home-row keys to the notes C4..C5.
- While a mapped key is held, it generates a square-wave sample for the audio DAC path; otherwise it drives silence.
- Replaces the direct byte-to-nibble hookup between keyboard and audio with a real key-held/tone model.

Parameters:
AMPLITUDE, 32'sd10000000, magnitude of the square-wave sample (signed, two's complement).
SAMPLE_W, 32, width of the sample output.

Ports:
CLOCK_50  input  1  system clock, 50 MHz.
resetn  input  1  asynchronous active-low reset (driven from KEY[0]).
received_data  input  8  scan-code byte from the PS/2 receiver.
received_data_en  input  1  one-cycle strobe; received_data is valid when this is high.
key_held  output  1  a mapped key is currently sounding.
note_index  output  3  0=C4, 1=D4, 2=E4, 3=F4, 4=G4, 5=A4, 6=B4, 7=C5.
half_period  output  17  CLOCK_50 cycles per half tone period for the current note.
last_code  output  8  last accepted make code, mapped or not.
tone_phase  output  1  current square-wave level.
sample  output  SAMPLE_W  signed audio sample: +AMPLITUDE, -AMPLITUDE, or 0.

Behaviour:
- Reset (asynchronous, all registers):
  - key_held=0, note_index=0, half_period=0, last_code=0, tone_phase=0, sample=0.
  - Parser returns to P_IDLE; tone counter is cleared.
  - Reset asserted mid-note silences the output immediately, with no completion of the half period.
- Parser FSM advances only on cycles where received_data_en=1. States:
  - P_IDLE: 8'hE0 -> P_E0; 8'hF0 -> P_F0; any other byte is a make code -> process make, stay in P_IDLE.
  - P_E0: 8'hF0 -> P_E0F0; any other byte is an extended make, which is ignored -> P_IDLE.
  - P_F0: 8'hF0 -> stay in P_F0; any other byte is a break code -> process break -> P_IDLE.
  - P_E0F0: any byte is an extended break, ignored -> P_IDLE.
- Key map (make code -> note_index, half_period):
  - 1C->0, 95556; 1B->1, 85131; 23->2, 75843; 2B->3, 71586.
  - 34->4, 63776; 33->5, 56818; 3B->6, 50619; 42->7, 47778.
- Make processing:
  - last_code <= byte.
  - If the byte is mapped: key_held<=1; note_index and half_period are loaded; the held code is stored internally.
  - If the mapped note differs from the sounding note, or the block was idle: tone counter <= 0 and tone_phase <= 1.
  - Typematic repeat of the same held key changes nothing apart from last_code; the counter is not restarted.
  - Unmapped make: key state is unchanged.
  - Last-pressed key wins when a new mapped key is pressed while another is held.
- Break processing: if the byte equals the stored held code, key_held<=0; otherwise the break is ignored (e.g. release of a key that was already superseded).
- Latency: strobe in cycle n -> key_held, note_index, half_period and last_code are valid in cycle n+1.
- Tone generator (runs when key_held=1):
  - Counter increments each cycle.
  - When counter == half_period-1: counter <= 0 and tone_phase toggles.
  - sample is registered: tone_phase=1 -> +AMPLITUDE; tone_phase=0 -> -AMPLITUDE. It follows tone_phase by one cycle.
- Tone generator (key_held=0): counter=0, tone_phase=0, sample=0 on the following cycle.
- Strobe arriving on the same cycle as a counter wrap: the make/break result takes priority over the wrap.
- received_data is ignored whenever received_data_en=0.

Test Plan:
- Reset then strobe 8'h1C:
  - Cycle+1: key_held=1, note_index=0, half_period=95556, tone_phase=1.
  - sample=+10000000 one cycle later.
  - tone_phase falls after 95556 cycles.
- With 1C held, strobe F0 then 1C: key_held=0 one cycle after the 1C strobe; sample=0 on the next cycle.
- Press 1C then 42 without a break:
  - note_index=7, half_period=47778, counter restarted.
  - Then F0,1C leaves key_held=1; then F0,42 gives key_held=0.
- Strobe E0,1C, then E0,F0,1C: key_held stays 0 throughout, last_code unchanged, parser back in P_IDLE (verified by a following 1B giving note_index=1).
- Hold 23 and repeat 23 every 1000 cycles: tone_phase toggle period stays exactly 75843 cycles (no restart). Strobe unmapped 8'h15: last_code=8'h15, note unchanged.
- Assert resetn=0 mid-note for 3 cycles: all outputs are 0 asynchronously. After release, a lone F0,1C does not set key_held.
